// File: rtl/mic_array_emu.sv
// I2S MEMS microphone array emulator: slaves to an external bit clock / word select and
// drives per-channel delayed PRBS or ramp sample streams for self-test of the capture path.
module mic_array_emu #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned SAMPLE_W  = 24,
    parameter int unsigned MAX_DELAY = 15,
    parameter int unsigned DLY_W     = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [1:0]                   mode_i,
    input  logic [2*NUM_LINES*DLY_W-1:0] delay_cfg_i,
    input  logic                         mic_clk_i,
    input  logic                         mic_ws_i,
    output logic [NUM_LINES-1:0]         mic_da_o,
    output logic [15:0]                  frame_cnt_o,
    output logic                         frame_stb_o
);

    localparam int unsigned NumCh  = 2 * NUM_LINES;
    localparam int unsigned HistD  = MAX_DELAY + 1;
    localparam int unsigned HistAw = (HistD > 1) ? $clog2(HistD) : 1;
    localparam int unsigned IdxW   = 6;

    localparam logic [IdxW-1:0]     SlotMax = 6'd63;
    localparam logic [IdxW-1:0]     SampW   = IdxW'(SAMPLE_W);
    localparam logic [DLY_W-1:0]    MaxDlyF = DLY_W'(MAX_DELAY);
    localparam logic [HistAw-1:0]   MaxIdx  = HistAw'(MAX_DELAY);
    localparam logic [SAMPLE_W-1:0] OneBit  = SAMPLE_W'(1);

    logic                  mclk_s1_q, mclk_s2_q, mclk_s3_q;
    logic                  ws_s1_q, ws_s2_q, ws_last_q;
    logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
    logic                  active_q;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  frame_stb_q;
    logic [NUM_LINES-1:0]  mic_da_q, mic_da_d;
    logic [HistAw-1:0]     dly_q [NumCh];
    logic [HistAw-1:0]     dly_d [NumCh];
    logic [SAMPLE_W-1:0]   hist_q [HistD];
    logic [SAMPLE_W-1:0]   new_sample;
    logic                  fall, ws_chg, frame_start;

    assign fall        = mclk_s3_q & ~mclk_s2_q;
    assign ws_chg      = ws_s2_q ^ ws_last_q;
    assign frame_start = fall & ws_last_q & ~ws_s2_q;

    always_comb begin
        bit_idx_d = '0;
        if (!ws_chg) begin
            bit_idx_d = (bit_idx_q == SlotMax) ? SlotMax : bit_idx_q + 6'd1;
        end
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        frame_cnt_d = frame_cnt_q + 16'd1;
        unique case (mode_i)
            2'd1:    new_sample = SAMPLE_W'(lfsr_d) << (SAMPLE_W - 16);
            2'd2:    new_sample = SAMPLE_W'(frame_cnt_d);
            default: new_sample = '0;
        endcase
    end

    // Out-of-range delay fields saturate to the deepest history entry.
    always_comb begin
        for (int c = 0; c < NumCh; c++) begin
            dly_d[c] = (delay_cfg_i[c*DLY_W +: DLY_W] > MaxDlyF) ? MaxIdx
                     : delay_cfg_i[c*DLY_W +: HistAw];
        end
    end

    // Bit k of a slot (1..SAMPLE_W) carries sample bit SAMPLE_W-k; everything else is 0.
    always_comb begin
        mic_da_d = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (active_q && (bit_idx_d != '0) && (bit_idx_d <= SampW)) begin
                mic_da_d[i] = |(hist_q[ws_s2_q ? dly_q[2*i+1] : dly_q[2*i]]
                                & (OneBit << (SampW - bit_idx_d)));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mclk_s1_q   <= 1'b0;
            mclk_s2_q   <= 1'b0;
            mclk_s3_q   <= 1'b0;
            ws_s1_q     <= 1'b0;
            ws_s2_q     <= 1'b0;
            ws_last_q   <= 1'b0;
            bit_idx_q   <= '0;
            active_q    <= 1'b0;
            lfsr_q      <= 16'hACE1;
            frame_cnt_q <= '0;
            frame_stb_q <= 1'b0;
            mic_da_q    <= '0;
            for (int c = 0; c < NumCh; c++) dly_q[c] <= '0;
            for (int j = 0; j < HistD; j++) hist_q[j] <= '0;
        end else begin
            mclk_s1_q   <= mic_clk_i;
            mclk_s2_q   <= mclk_s1_q;
            mclk_s3_q   <= mclk_s2_q;
            ws_s1_q     <= mic_ws_i;
            ws_s2_q     <= ws_s1_q;
            frame_stb_q <= 1'b0;
            if (fall) begin
                ws_last_q <= ws_s2_q;
                bit_idx_q <= bit_idx_d;
                mic_da_q  <= mic_da_d;
            end
            if (frame_start) begin
                active_q <= en_i;
                for (int c = 0; c < NumCh; c++) dly_q[c] <= dly_d[c];
                if (en_i) begin
                    lfsr_q      <= lfsr_d;
                    frame_cnt_q <= frame_cnt_d;
                    frame_stb_q <= 1'b1;
                    hist_q[0]   <= new_sample;
                    for (int j = 1; j < HistD; j++) hist_q[j] <= hist_q[j-1];
                end
            end
        end
    end

    assign mic_da_o    = mic_da_q;
    assign frame_cnt_o = frame_cnt_q;
    assign frame_stb_o = frame_stb_q;

endmodule
